// File: rtl/rob_retire_ctrl.sv
// -----------------------------------------------------------------------------
// rob_retire_ctrl
//
// In-order retirement controller for the rename free list.
//
// Each renamed instruction is allocated one reorder-buffer entry at the tail.
// The entry records whether the instruction writes a destination, the
// architectural destination, and the physical register the destination used
// to map to. Instructions complete out of order through writeback tags. At
// most one instruction retires per cycle, always the one at the head, and the
// displaced physical register goes back to rename's free list.
//
// Optional feature (compile-time macro ROB_PERF_CNT_EN):
//   adds perf_full_stall_cnt and perf_retire_cnt. With the macro undefined
//   these ports and their registers do not exist.
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous, active-high reset
//   dispatch_valid      in   instruction presented for allocation
//   dispatch_has_rd     in   instruction writes a destination register
//   dispatch_rd         in   architectural destination
//   dispatch_old_phys   in   previous mapping of dispatch_rd, freed at retire
//   dispatch_ready      out  entry available (combinational, = !rob_full)
//   dispatch_rob_idx    out  index assigned to the current dispatch (= tail)
//   wb_valid            in   execution complete
//   wb_rob_idx          in   entry completing
//   retire_valid        out  registered one-cycle pulse per retirement
//   retire_free_valid   out  registered; retirement of an entry with a dest
//   retire_phys_reg     out  registered; physical register to free (holds)
//   retire_arch_rd      out  registered; architectural rd retired (holds)
//   rob_count           out  registered occupancy, 0..ROB_DEPTH
//   rob_empty           out  registered, rob_count == 0
//   rob_full            out  registered, rob_count == ROB_DEPTH
//   perf_full_stall_cnt out  (ROB_PERF_CNT_EN) cycles with dispatch blocked
//   perf_retire_cnt     out  (ROB_PERF_CNT_EN) total retirements
// -----------------------------------------------------------------------------
module rob_retire_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = 4,
  parameter int PHYS_W    = 6,
  parameter int ARCH_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dispatch_valid,
  input  logic                 dispatch_has_rd,
  input  logic [ARCH_W-1:0]    dispatch_rd,
  input  logic [PHYS_W-1:0]    dispatch_old_phys,
  output logic                 dispatch_ready,
  output logic [ROB_IDX_W-1:0] dispatch_rob_idx,
  input  logic                 wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_rob_idx,
  output logic                 retire_valid,
  output logic                 retire_free_valid,
  output logic [PHYS_W-1:0]    retire_phys_reg,
  output logic [ARCH_W-1:0]    retire_arch_rd,
  output logic [ROB_IDX_W:0]   rob_count,
  output logic                 rob_empty,
  output logic                 rob_full
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_full_stall_cnt,
  output logic [31:0]          perf_retire_cnt
`endif
);

  localparam logic [ROB_IDX_W:0]   DEPTH_C   = (ROB_IDX_W + 1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W:0]   CNT_ZERO  = {(ROB_IDX_W + 1){1'b0}};
  localparam logic [ROB_IDX_W:0]   CNT_ONE   = {{ROB_IDX_W{1'b0}}, 1'b1};
  localparam logic [ROB_IDX_W-1:0] IDX_ZERO  = {ROB_IDX_W{1'b0}};
  localparam logic [ROB_IDX_W-1:0] IDX_ONE   = {{(ROB_IDX_W - 1){1'b0}}, 1'b1};
  localparam logic [ROB_DEPTH-1:0] ENT_ZERO  = {ROB_DEPTH{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ROB_IDX_W-1:0] head_r;
  logic [ROB_IDX_W-1:0] tail_r;
  logic [ROB_IDX_W:0]   count_r;
  logic                 empty_r;
  logic                 full_r;

  // Per-entry control bits live in flat vectors so they can be reset as a
  // whole; the payload below is never reset because an entry is only read
  // after it has been written by an allocation.
  logic [ROB_DEPTH-1:0] valid_r;
  logic [ROB_DEPTH-1:0] done_r;

  logic                 has_rd_r   [ROB_DEPTH];
  logic [ARCH_W-1:0]    rd_r       [ROB_DEPTH];
  logic [PHYS_W-1:0]    old_phys_r [ROB_DEPTH];

  logic                 retire_valid_r;
  logic                 retire_free_valid_r;
  logic [PHYS_W-1:0]    retire_phys_reg_r;
  logic [ARCH_W-1:0]    retire_arch_rd_r;

  // ---------------------------------------------------------------------------
  // Edge decisions (all evaluated on pre-edge state)
  // ---------------------------------------------------------------------------
  logic                 alloc_s;
  logic                 retire_s;
  logic                 wb_hit_s;
  logic [ROB_IDX_W:0]   count_next_s;

  // Allocation is gated by the registered full flag only, so a retirement on
  // the same edge never lets a dispatch slip into a full buffer.
  assign alloc_s  = dispatch_valid & ~full_r;
  assign retire_s = valid_r[head_r] & done_r[head_r];
  // A writeback to an entry that is not allocated is simply dropped.
  assign wb_hit_s = wb_valid & valid_r[wb_rob_idx];

  // Next occupancy from the allocate/retire pair of this edge.
  always_comb begin
    count_next_s = count_r;
    case ({alloc_s, retire_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------

  // Head/tail advance and wrap naturally modulo ROB_DEPTH; full/empty come
  // from the occupancy counter, never from pointer equality.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= IDX_ZERO;
      tail_r  <= IDX_ZERO;
      count_r <= CNT_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (retire_s) begin
        head_r <= head_r + IDX_ONE;
      end
      if (alloc_s) begin
        tail_r <= tail_r + IDX_ONE;
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == CNT_ZERO);
      full_r  <= (count_next_s == DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Entry control bits
  // ---------------------------------------------------------------------------

  // Writeback, retirement and allocation touch distinct entries: allocation
  // only happens at an invalid tail, so it can never collide with a
  // writeback hit, and head == tail with both active is impossible because
  // that needs the buffer to be simultaneously full and empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= ENT_ZERO;
      done_r  <= ENT_ZERO;
    end else begin
      if (wb_hit_s) begin
        done_r[wb_rob_idx] <= 1'b1;
      end
      if (retire_s) begin
        valid_r[head_r] <= 1'b0;
      end
      if (alloc_s) begin
        valid_r[tail_r] <= 1'b1;
        done_r[tail_r]  <= 1'b0;
      end
    end
  end

  // Entry payload capture at allocation.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      has_rd_r[tail_r]   <= dispatch_has_rd;
      rd_r[tail_r]       <= dispatch_rd;
      old_phys_r[tail_r] <= dispatch_old_phys;
    end
  end

  // ---------------------------------------------------------------------------
  // Retire outputs
  // ---------------------------------------------------------------------------

  // The valid strobes pulse for one cycle per retirement; the register and
  // rd fields keep their last retired values while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_valid_r      <= 1'b0;
      retire_free_valid_r <= 1'b0;
      retire_phys_reg_r   <= {PHYS_W{1'b0}};
      retire_arch_rd_r    <= {ARCH_W{1'b0}};
    end else begin
      if (retire_s) begin
        retire_valid_r      <= 1'b1;
        retire_free_valid_r <= has_rd_r[head_r];
        retire_phys_reg_r   <= old_phys_r[head_r];
        retire_arch_rd_r    <= rd_r[head_r];
      end else begin
        retire_valid_r      <= 1'b0;
        retire_free_valid_r <= 1'b0;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_full_stall_cnt_r;
  logic [31:0] perf_retire_cnt_r;

  // Count blocked-dispatch cycles and retirements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_full_stall_cnt_r <= 32'd0;
      perf_retire_cnt_r     <= 32'd0;
    end else begin
      if (dispatch_valid && full_r) begin
        perf_full_stall_cnt_r <= perf_full_stall_cnt_r + 32'd1;
      end
      if (retire_s) begin
        perf_retire_cnt_r <= perf_retire_cnt_r + 32'd1;
      end
    end
  end

  assign perf_full_stall_cnt = perf_full_stall_cnt_r;
  assign perf_retire_cnt     = perf_retire_cnt_r;
`endif

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign dispatch_ready    = ~full_r;
  assign dispatch_rob_idx  = tail_r;
  assign retire_valid      = retire_valid_r;
  assign retire_free_valid = retire_free_valid_r;
  assign retire_phys_reg   = retire_phys_reg_r;
  assign retire_arch_rd    = retire_arch_rd_r;
  assign rob_count         = count_r;
  assign rob_empty         = empty_r;
  assign rob_full          = full_r;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_retire_ctrl
//
// Self-checking bench for rob_retire_ctrl. A queue of in-flight instructions
// in program order serves as the reference: allocation pushes, writeback marks
// the matching entry done, and the front entry pops once it is done. Every
// cycle the DUT's outputs are compared with that queue. Directed sequences
// with hand-computed literals pin the reference, followed by a randomized
// phase with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_rob_retire_ctrl;

  logic       clk;
  logic       reset;
  logic       dispatch_valid;
  logic       dispatch_has_rd;
  logic [4:0] dispatch_rd;
  logic [5:0] dispatch_old_phys;
  logic       dispatch_ready;
  logic [3:0] dispatch_rob_idx;
  logic       wb_valid;
  logic [3:0] wb_rob_idx;
  logic       retire_valid;
  logic       retire_free_valid;
  logic [5:0] retire_phys_reg;
  logic [4:0] retire_arch_rd;
  logic [4:0] rob_count;
  logic       rob_empty;
  logic       rob_full;

  rob_retire_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .dispatch_valid    (dispatch_valid),
    .dispatch_has_rd   (dispatch_has_rd),
    .dispatch_rd       (dispatch_rd),
    .dispatch_old_phys (dispatch_old_phys),
    .dispatch_ready    (dispatch_ready),
    .dispatch_rob_idx  (dispatch_rob_idx),
    .wb_valid          (wb_valid),
    .wb_rob_idx        (wb_rob_idx),
    .retire_valid      (retire_valid),
    .retire_free_valid (retire_free_valid),
    .retire_phys_reg   (retire_phys_reg),
    .retire_arch_rd    (retire_arch_rd),
    .rob_count         (rob_count),
    .rob_empty         (rob_empty),
    .rob_full          (rob_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight instructions, oldest first.
  typedef struct {
    int idx;
    bit has;
    int rd;
    int old;
    bit done;
  } ent_t;

  ent_t q[$];
  int   mtail;
  bit   exp_rv;
  bit   exp_fv;
  int   exp_phys;
  int   exp_arch;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mtail    = 0;
    exp_rv   = 1'b0;
    exp_fv   = 1'b0;
    exp_phys = 0;
    exp_arch = 0;
  endtask

  // Registered outputs against the reference.
  task automatic check_regs();
    chk("retire_valid", retire_valid, exp_rv);
    chk("retire_free_valid", retire_free_valid, exp_fv);
    chk("retire_phys_reg", retire_phys_reg, exp_phys);
    chk("retire_arch_rd", retire_arch_rd, exp_arch);
    chk("rob_count", rob_count, q.size());
    chk("rob_empty", rob_empty, q.size() == 0);
    chk("rob_full", rob_full, q.size() == 16);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model over the edge, then check the registered outputs.
  task automatic step(input bit dv, input bit hr, input int rd, input int old,
                      input bit wv, input int wi);
    bit   ret;
    bit   al;
    ent_t e;
    dispatch_valid    = dv;
    dispatch_has_rd   = hr;
    dispatch_rd       = rd[4:0];
    dispatch_old_phys = old[5:0];
    wb_valid          = wv;
    wb_rob_idx        = wi[3:0];
    #1;
    chk("dispatch_ready", dispatch_ready, q.size() < 16);
    chk("dispatch_rob_idx", dispatch_rob_idx, mtail);
    ret = (q.size() > 0) && q[0].done;
    al  = dv && (q.size() < 16);
    if (wv) begin
      foreach (q[k]) begin
        if (q[k].idx == wi) q[k].done = 1'b1;
      end
    end
    if (ret) begin
      e        = q.pop_front();
      exp_rv   = 1'b1;
      exp_fv   = e.has;
      exp_phys = e.old;
      exp_arch = e.rd;
    end else begin
      exp_rv = 1'b0;
      exp_fv = 1'b0;
    end
    if (al) begin
      e.idx  = mtail;
      e.has  = hr;
      e.rd   = rd & 31;
      e.old  = old & 63;
      e.done = 1'b0;
      q.push_back(e);
      mtail = (mtail + 1) % 16;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic wb(input int wi);
    step(1'b0, 1'b0, 0, 0, 1'b1, wi);
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear
  // before any further edge.
  task automatic async_reset();
    dispatch_valid = 1'b0;
    wb_valid       = 1'b0;
    reset          = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("rst_dispatch_rob_idx", dispatch_rob_idx, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int wi;
    reset             = 1'b1;
    dispatch_valid    = 1'b0;
    dispatch_has_rd   = 1'b0;
    dispatch_rd       = 5'd0;
    dispatch_old_phys = 6'd0;
    wb_valid          = 1'b0;
    wb_rob_idx        = 4'd0;
    model_reset();
    #2;
    check_regs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. Reset then idle.
    idle();
    idle();
    chk("t1_empty", rob_empty, 1);
    chk("t1_count", rob_count, 0);
    chk("t1_retire_valid", retire_valid, 0);
    chk("t1_rob_idx", dispatch_rob_idx, 0);

    // 2. Fill with old_phys 32..47 (entry 4 has no destination), then one
    //    more dispatch against a full buffer.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i != 4), i, 32 + i, 1'b0, 0);
    end
    chk("t2_full", rob_full, 1);
    chk("t2_ready", dispatch_ready, 0);
    step(1'b1, 1'b1, 7, 60, 1'b0, 0);
    chk("t2_count_after_17th", rob_count, 16);
    chk("t2_tail_after_17th", dispatch_rob_idx, 0);

    // 3. Writeback 2, 1, 0 then three back-to-back retirements.
    wb(2);
    chk("t3_no_retire_wb2", retire_valid, 0);
    wb(1);
    chk("t3_no_retire_wb1", retire_valid, 0);
    wb(0);
    chk("t3_no_retire_wb0_edge", retire_valid, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t3_retire_valid", retire_valid, 1);
      chk("t3_retire_free", retire_free_valid, 1);
      chk("t3_retire_phys", retire_phys_reg, 32 + i);
    end
    idle();
    chk("t3_retire_stops", retire_valid, 0);
    chk("t3_phys_holds", retire_phys_reg, 34);

    // 4. Refill to full, complete the head, then dispatch on the retire edge.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 20 + i, 48 + i, 1'b0, 0);
    end
    chk("t4_full", rob_full, 1);
    wb(3);
    step(1'b1, 1'b1, 9, 51, 1'b0, 0);
    chk("t4_count", rob_count, 15);
    chk("t4_ready", dispatch_ready, 1);
    chk("t4_retire_phys", retire_phys_reg, 35);

    // 5. Entry without a destination, then drain through the wrap.
    wb(4);
    idle();
    chk("t5_retire_valid", retire_valid, 1);
    chk("t5_free_valid", retire_free_valid, 0);
    chk("t5_tail_wrapped", dispatch_rob_idx, 3);
    while (q.size() > 0 && !q[q.size() - 1].done) begin
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].done) begin
          wi = q[k].idx;
          break;
        end
      end
      wb(wi);
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) idle();
    idle();
    chk("t5_drained_empty", rob_empty, 1);
    chk("t5_last_phys", retire_phys_reg, 50);

    // 6. Reset with five entries pending; stale writebacks do nothing.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, i, 10 + i, 1'b0, 0);
    end
    wb(3);
    wb(4);
    async_reset();
    chk("t6_retire_valid", retire_valid, 0);
    chk("t6_count", rob_count, 0);
    for (int i = 3; i < 8; i++) wb(i);
    idle();
    chk("t6_no_stale_retire", retire_valid, 0);
    chk("t6_still_empty", rob_empty, 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      bit dv;
      bit wv;
      dv = ($urandom_range(0, 9) < 6);
      wv = ($urandom_range(0, 9) < 6);
      if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
        wi = q[$urandom_range(0, q.size() - 1)].idx;
      end else begin
        wi = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        step(dv, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
             $urandom_range(0, 63), wv, wi);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_retire_ctrl.md
Name: rob_retire_ctrl

Overview:
In-order retirement controller that sequences the rename free list. Sits between dispatch/writeback and the rename stage.
- Every renamed instruction is allocated a reorder-buffer entry holding the physical register its destination previously mapped to.
- Instructions complete out of order via writeback tags.
- The block retires at most one instruction per cycle, in program order.
- On retirement it returns the displaced physical register to rename's free list via a retire_valid / retire_phys_reg style pair.

Parameters:
ROB_DEPTH, 16, number of entries (power of two)
ROB_IDX_W, 4, log2(ROB_DEPTH)
PHYS_W, 6, physical register tag width
ARCH_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
dispatch_valid  in  1  instruction presented for allocation
dispatch_has_rd  in  1  instruction writes a destination register
dispatch_rd  in  ARCH_W  architectural destination
dispatch_old_phys  in  PHYS_W  previous mapping of dispatch_rd, freed at retire
dispatch_ready  out  1  entry available (combinational, = !rob_full)
dispatch_rob_idx  out  ROB_IDX_W  index assigned to the current dispatch (= tail)
wb_valid  in  1  execution complete
wb_rob_idx  in  ROB_IDX_W  entry completing
retire_valid  out  1  registered, one-cycle pulse per retired instruction
retire_free_valid  out  1  registered; retire_valid && entry had a destination (drives rename retire_valid)
retire_phys_reg  out  PHYS_W  registered; old physical register to free
retire_arch_rd  out  ARCH_W  registered; architectural rd of retired entry
rob_count  out  ROB_IDX_W+1  registered occupancy, 0..ROB_DEPTH
rob_empty  out  1  rob_count == 0
rob_full  out  1  rob_count == ROB_DEPTH

Behaviour:
- Reset (async, any time, including mid-operation):
  - head = tail = 0; all entry valid/done bits = 0; rob_count = 0.
  - All retire_* outputs = 0; rob_empty = 1; rob_full = 0.
  - Entry payload need not be cleared.
- Pointers: head and tail are ROB_IDX_W bits and wrap modulo ROB_DEPTH. Full/empty are derived from rob_count, not from pointer equality.
- Allocate:
  - Occurs on an edge where dispatch_valid && dispatch_ready.
  - Writes {valid=1, done=0, has_rd, rd, old_phys} at tail; tail advances by 1.
  - dispatch_valid while full is ignored: no state change and no error output.
- Writeback:
  - Occurs on an edge where wb_valid: if entry[wb_rob_idx].valid, set done=1.
  - Writeback to an invalid entry is ignored. A repeated writeback is harmless.
- Retire decision (combinational): retire_now = entry[head].valid && entry[head].done, evaluated on pre-edge state.
  - On that edge: clear entry[head].valid; advance head.
  - Register retire_valid=1, retire_free_valid=has_rd, retire_phys_reg=old_phys, retire_arch_rd=rd.
  - Otherwise retire_valid and retire_free_valid = 0. retire_phys_reg and retire_arch_rd hold their last values.
- Latency: writeback sampled at edge E; the earliest retire edge is E+1; retire outputs are high in the cycle after E+1. Writeback never retires on its own edge.
- Simultaneous events:
  - Allocate + retire on one edge: rob_count unchanged. At count == ROB_DEPTH, dispatch_ready is 0 regardless of the concurrent retire (no pass-through).
  - Writeback to head on the same edge as allocate: independent, both take effect.
  - Allocate at index i is only possible after i has retired, so writeback and allocate never target the same valid entry.
- Count: rob_count += alloc − retire, saturation-free by construction.

Optional Feature:
ROB_PERF_CNT_EN:
- When defined, adds two outputs:
  - perf_full_stall_cnt (32 bits): increments every cycle with dispatch_valid && rob_full.
  - perf_retire_cnt (32 bits): increments on every retire edge.
- Both counters are cleared by reset and wrap at 2^32.
- When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset then idle → rob_empty=1, rob_count=0, retire_valid=0, dispatch_rob_idx=0.
2. Dispatch 16 instructions with old_phys=32..47 → rob_full=1, dispatch_ready=0; a 17th dispatch_valid causes no change.
3. Writeback indices 2, 1, 0 on consecutive cycles → no retire until idx 0 is done. Then on three consecutive cycles retire_phys_reg = 32, 33, 34 with retire_free_valid=1.
4. Full ROB, head done; dispatch and retire on the same edge → dispatch not accepted; next cycle count=15 and dispatch_ready=1.
5. Entry with dispatch_has_rd=0 retires → retire_valid=1, retire_free_valid=0. Head wraps from 15 to 0 correctly after 17 total allocations.
6. Assert reset mid-stream with 5 entries pending → outputs 0 immediately. After release, wb_valid to old indices produces no retire.
